// File: rtl/tmds_pkg.sv
`timescale 1ns/1ps
// tmds_pkg: shared definitions for the TMDS receive channel.
//   - the four 10-bit control-token words
//   - alignment FSM state encoding
//   - token_map(): 10-bit word -> {is_token, c1, c0}
package tmds_pkg;

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    WAIT   = 2'd1,
    LOCKED = 2'd2
  } tmds_state_e;

  // Returns {hit, c1, c0}; hit=0 for any non-token word.
  function automatic logic [2:0] token_map(input logic [9:0] w);
    case (w)
      TOK_00:  token_map = 3'b100;
      TOK_01:  token_map = 3'b101;
      TOK_10:  token_map = 3'b110;
      TOK_11:  token_map = 3'b111;
      default: token_map = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tmds_word_decode.sv
`timescale 1ns/1ps
// tmds_word_decode: purely combinational decode of one 10-bit TMDS word.
//   din      in  10  TMDS word, bit 0 first-received
//   is_token out 1   word is one of the four control tokens
//   c1, c0   out 1   control pair (0 when not a token)
//   dout     out 8   decoded pixel byte (0 for tokens)
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] din,
  output logic       is_token,
  output logic       c1,
  output logic       c0,
  output logic [7:0] dout
);

  logic [2:0] tok;
  logic [7:0] q;

  always_comb begin
    tok      = token_map(din);
    is_token = tok[2];
    c1       = tok[1];
    c0       = tok[0];
    // bit 9 marks an inverted payload, bit 8 selects XOR vs XNOR chaining
    q        = din[9] ? ~din[7:0] : din[7:0];
    dout     = '0;
    if (!tok[2]) begin
      dout[0] = q[0];
      for (int i = 1; i < 8; i++)
        dout[i] = din[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
`timescale 1ns/1ps
// tmds_channel_decoder: one TMDS receive channel. Word-aligns the deserializer
// via bitslip pulses until control tokens appear, then decodes each word.
//   iclk      in  1   pixel-rate clock
//   RST       in  1   asynchronous active-low reset
//   din       in  10  raw TMDS word, bit 0 first-received
//   din_valid in  1   din qualifier
//   bitslip   out 1   one-cycle rotate request to the deserializer
//   aligned   out 1   high while in LOCKED
//   dout      out 8   pixel byte (vld && de)
//   c0, c1    out 1   control pair (vld && !de)
//   de        out 1   1 = data word, 0 = control token
//   vld       out 1   output word valid, din_valid delayed 2 cycles
//   lost_cnt  out 16  saturating LOCKED->SEARCH count
// Optional: define TMDS_LOST_CNT_EN to build the lost_cnt counter; otherwise
// lost_cnt is tied to 0.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int TOKEN_CNT_MIN  = 8,
  parameter int SEARCH_TIMEOUT = 64,
  parameter int SLIP_WAIT      = 8,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic        iclk,
  input  logic        RST,
  input  logic [9:0]  din,
  input  logic        din_valid,
  output logic        bitslip,
  output logic        aligned,
  output logic [7:0]  dout,
  output logic        c0,
  output logic        c1,
  output logic        de,
  output logic        vld,
  output logic [15:0] lost_cnt
);

  localparam int STAGES   = 2;
  localparam int MISS_MAX = (LOCK_TIMEOUT > SEARCH_TIMEOUT) ? LOCK_TIMEOUT : SEARCH_TIMEOUT;
  localparam int TOK_W    = $clog2(TOKEN_CNT_MIN) + 1;
  localparam int MISS_W   = $clog2(MISS_MAX) + 1;
  localparam int WAIT_W   = $clog2(SLIP_WAIT) + 1;

  localparam logic [TOK_W-1:0]  TOK_THR  = TOK_W'(TOKEN_CNT_MIN);
  localparam logic [MISS_W-1:0] SRCH_THR = MISS_W'(SEARCH_TIMEOUT);
  localparam logic [MISS_W-1:0] LOCK_THR = MISS_W'(LOCK_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_THR = WAIT_W'(SLIP_WAIT);

  // ---- stage 1: capture word ----
  logic [STAGES:1] vld_pipe;
  logic [9:0]      s1_din;

  always_ff @(posedge iclk or negedge RST)
    if (!RST) begin
      vld_pipe <= '0;
      s1_din   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], din_valid};
      if (din_valid) s1_din <= din;
    end

  assign vld = vld_pipe[STAGES];

  // One decoder on the stage-1 word feeds both the output stage and the FSM.
  logic       s1_tok, s1_c1, s1_c0;
  logic [7:0] s1_dout;

  tmds_word_decode u_dec (
    .din      (s1_din),
    .is_token (s1_tok),
    .c1       (s1_c1),
    .c0       (s1_c0),
    .dout     (s1_dout)
  );

  // ---- stage 2: registered outputs; c0/c1 keep the last token across data ----
  always_ff @(posedge iclk or negedge RST)
    if (!RST) begin
      dout <= '0;
      de   <= 1'b0;
      c0   <= 1'b0;
      c1   <= 1'b0;
    end else if (vld_pipe[1]) begin
      de   <= ~s1_tok;
      dout <= s1_dout;
      if (s1_tok) begin
        c0 <= s1_c0;
        c1 <= s1_c1;
      end
    end

  // ---- alignment FSM ----
  tmds_state_e       state, state_nxt;
  logic [TOK_W-1:0]  tok_cnt, tok_nxt;
  logic [MISS_W-1:0] miss_cnt, miss_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              slip_nxt;

  always_ff @(posedge iclk or negedge RST)
    if (!RST) begin
      state    <= SEARCH;
      tok_cnt  <= '0;
      miss_cnt <= '0;
      wait_cnt <= '0;
      bitslip  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tok_cnt  <= tok_nxt;
      miss_cnt <= miss_nxt;
      wait_cnt <= wait_nxt;
      bitslip  <= slip_nxt;
    end

  always_comb begin
    state_nxt = state;
    tok_nxt   = tok_cnt;
    miss_nxt  = miss_cnt;
    wait_nxt  = wait_cnt;
    slip_nxt  = 1'b0;
    case (state)
      SEARCH: if (vld_pipe[1]) begin
        if (s1_tok) begin
          // a token never advances miss_cnt, so it can never trigger a slip
          tok_nxt = tok_cnt + 1'b1;
          if (tok_nxt == TOK_THR) begin
            state_nxt = LOCKED;
            tok_nxt   = '0;
            miss_nxt  = '0;
          end
        end else begin
          tok_nxt  = '0;
          miss_nxt = miss_cnt + 1'b1;
          if (miss_nxt == SRCH_THR) begin
            state_nxt = WAIT;
            slip_nxt  = 1'b1;
            miss_nxt  = '0;
          end
        end
      end
      // deserializer settle time: counts every clock, input ignored
      WAIT: begin
        wait_nxt = wait_cnt + 1'b1;
        if (wait_nxt == WAIT_THR) begin
          state_nxt = SEARCH;
          wait_nxt  = '0;
        end
      end
      LOCKED: if (vld_pipe[1]) begin
        if (s1_tok) miss_nxt = '0;
        else begin
          miss_nxt = miss_cnt + 1'b1;
          if (miss_nxt == LOCK_THR) begin
            state_nxt = SEARCH;
            miss_nxt  = '0;
            tok_nxt   = '0;
          end
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  assign aligned = (state == LOCKED);

`ifdef TMDS_LOST_CNT_EN
  logic        lost_evt;
  logic [15:0] lost_q;

  assign lost_evt = (state == LOCKED) && (state_nxt == SEARCH);

  always_ff @(posedge iclk or negedge RST)
    if (!RST) lost_q <= '0;
    else if (lost_evt && (lost_q != 16'hFFFF)) lost_q <= lost_q + 1'b1;

  assign lost_cnt = lost_q;
`else
  assign lost_cnt = '0;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
`timescale 1ns/1ps
// tb_tmds_channel_decoder: decode vector table, directed alignment/reset
// sequences and a randomized stream checked against a reference model.
module tb_tmds_channel_decoder;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] D00 = 10'b0100000000;

  localparam int TOKEN_CNT_MIN  = 8;
  localparam int SEARCH_TIMEOUT = 64;
  localparam int SLIP_WAIT      = 8;
  localparam int LOCK_TIMEOUT   = 4096;

  logic        iclk = 1'b0;
  logic        RST = 1'b0;
  logic [9:0]  din = '0;
  logic        din_valid = 1'b0;
  logic        bitslip, aligned, c0, c1, de, vld;
  logic [7:0]  dout;
  logic [15:0] lost_cnt;

  tmds_channel_decoder dut (
    .iclk      (iclk),
    .RST       (RST),
    .din       (din),
    .din_valid (din_valid),
    .bitslip   (bitslip),
    .aligned   (aligned),
    .dout      (dout),
    .c0        (c0),
    .c1        (c1),
    .de        (de),
    .vld       (vld),
    .lost_cnt  (lost_cnt)
  );

  always #5 iclk = ~iclk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input logic [9:0] d, input logic v);
    din = d;
    din_valid = v;
    @(posedge iclk);
    #1;
    cyc++;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_bitslip"}, bitslip, 0);
    chk({nm, "_aligned"}, aligned, 0);
    chk({nm, "_vld"}, vld, 0);
    chk({nm, "_de"}, de, 0);
    chk({nm, "_dout"}, dout, 0);
    chk({nm, "_c"}, {c1, c0}, 0);
    chk({nm, "_lost"}, lost_cnt, 0);
  endtask

  // ---------------- reference model ----------------
  localparam int M_SEARCH = 0, M_WAIT = 1, M_LOCKED = 2;
  int         m_mode, m_run, m_miss, m_wait, m_lost;
  logic [9:0] m_s1;
  logic       m_s1v;
  logic       o_vld, o_de, o_slip;
  logic [1:0] o_c;
  logic [7:0] o_dout;

  // {is_token, c1c0, byte} straight from the TMDS decode rules
  function automatic logic [10:0] ref_dec(input logic [9:0] w);
    logic [7:0] q, d;
    case (w)
      T00: return {1'b1, 2'b00, 8'h00};
      T01: return {1'b1, 2'b01, 8'h00};
      T10: return {1'b1, 2'b10, 8'h00};
      T11: return {1'b1, 2'b11, 8'h00};
      default: ;
    endcase
    q = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return {1'b0, 2'b00, d};
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
    logic [19:0] ww;
    ww = {w, w} << n;
    return ww[19:10];
  endfunction

  task automatic model_reset();
    m_mode = M_SEARCH; m_run = 0; m_miss = 0; m_wait = 0; m_lost = 0;
    m_s1 = '0; m_s1v = 1'b0;
    o_vld = 0; o_de = 0; o_slip = 0; o_c = '0; o_dout = '0;
  endtask

  // One clock edge: output and alignment act on the previously captured word.
  task automatic model_edge(input logic [9:0] d, input logic v);
    logic [10:0] r;
    r = ref_dec(m_s1);
    o_slip = 1'b0;
    o_vld = m_s1v;
    if (m_s1v) begin
      o_de = ~r[10];
      o_dout = r[7:0];
      if (r[10]) o_c = r[9:8];
    end
    if (m_mode == M_WAIT) begin
      m_wait++;
      if (m_wait == SLIP_WAIT) begin m_mode = M_SEARCH; m_wait = 0; end
    end else if (m_s1v) begin
      if (m_mode == M_SEARCH) begin
        if (r[10]) begin
          m_run++;
          if (m_run == TOKEN_CNT_MIN) begin m_mode = M_LOCKED; m_run = 0; m_miss = 0; end
        end else begin
          m_run = 0;
          m_miss++;
          if (m_miss == SEARCH_TIMEOUT) begin m_mode = M_WAIT; o_slip = 1'b1; m_miss = 0; end
        end
      end else begin
        if (r[10]) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss == LOCK_TIMEOUT) begin
            m_mode = M_SEARCH; m_miss = 0; m_run = 0;
            if (m_lost < 65535) m_lost++;
          end
        end
      end
    end
    if (v) m_s1 = d;
    m_s1v = v;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    din = '0;
    din_valid = 1'b0;
    repeat (2) @(posedge iclk);
    #1;
    RST = 1'b1;
    model_reset();
  endtask

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [9:0] din;
    logic       de;
    logic [7:0] dout;
    logic [1:0] c;
  } vec_t;

  vec_t tbl [11];

  logic [9:0]  w;
  logic        v, got;
  int          kind, len, nslip, last_slip, off, n, vcnt;
  logic [31:0] r32;
  logic        vh [0:31];
  logic [15:0] exp_lost;

  initial begin
    tbl[0]  = '{T00,            1'b0, 8'h00, 2'b00};
    tbl[1]  = '{D00,            1'b1, 8'h00, 2'b00};
    tbl[2]  = '{T11,            1'b0, 8'h00, 2'b11};
    tbl[3]  = '{10'b0011111111, 1'b1, 8'hFF, 2'b11};
    tbl[4]  = '{10'b1100000000, 1'b1, 8'h01, 2'b11};
    tbl[5]  = '{T01,            1'b0, 8'h00, 2'b01};
    tbl[6]  = '{10'b0100000001, 1'b1, 8'h03, 2'b01};
    tbl[7]  = '{T10,            1'b0, 8'h00, 2'b10};
    tbl[8]  = '{10'b0101010101, 1'b1, 8'hFF, 2'b10};
    tbl[9]  = '{10'b0001010101, 1'b1, 8'h01, 2'b10};
    tbl[10] = '{10'b1000000000, 1'b1, 8'hFF, 2'b10};

    // reset state
    do_reset();
    chk_zero("reset");

    // table: word in, then an idle cycle; result shows after the idle edge
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].din, 1'b1);
      step(tbl[i].din, 1'b0);
      chk("tbl_vld", vld, 1);
      chk("tbl_de", de, tbl[i].de);
      chk("tbl_dout", dout, tbl[i].dout);
      chk("tbl_c", {c1, c0}, tbl[i].c);
    end

    // 10 aligned tokens: lock after the 8th token reaches the FSM
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step(T00, 1'b1);
      chk("tok_aligned", aligned, (i >= 9));
      chk("tok_vld", vld, (i >= 2));
      chk("tok_de", de, 0);
      chk("tok_c", {c1, c0}, 0);
      chk("tok_bitslip", bitslip, 0);
    end

    // stream rotated by 3 bits; each slip undoes one bit of rotation
    do_reset();
    off = 3; nslip = 0; last_slip = 0;
    for (int i = 0; i < 1000; i++) begin
      step(rotl(T00, off), 1'b1);
      if (bitslip) begin
        if (nslip > 0) chk("slip_gap_ge72", (cyc - last_slip >= 72), 1);
        last_slip = cyc;
        nslip++;
        off = (off + 9) % 10;
      end
      if (aligned) break;
    end
    chk("rot_slips", nslip, 3);
    chk("rot_aligned", aligned, 1);
    for (int i = 0; i < 5; i++) begin
      step(T00, 1'b1);
      chk("rot_no_slip", bitslip, 0);
      chk("rot_hold", aligned, 1);
    end
    chk("rot_lost0", lost_cnt, 0);

    // locked, then LOCK_TIMEOUT data words drop lock
    for (int i = 1; i <= LOCK_TIMEOUT + 1; i++) begin
      step(D00, 1'b1);
      if (i == 3) begin
        chk("lock_data_vld", vld, 1);
        chk("lock_data_de", de, 1);
        chk("lock_data_dout", dout, 8'h00);
      end
      if (i == LOCK_TIMEOUT) chk("lock_hold_last", aligned, 1);
      if (i == LOCK_TIMEOUT + 1) chk("lock_drop", aligned, 0);
    end
`ifdef TMDS_LOST_CNT_EN
    exp_lost = 16'd1;
`else
    exp_lost = 16'd0;
`endif
    chk("lost_cnt", lost_cnt, exp_lost);

    // reset during the bitslip cycle
    do_reset();
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(D00, 1'b1);
      if (bitslip) begin got = 1'b1; break; end
    end
    chk("rst_slip_reached", got, 1);
    RST = 1'b0;
    #1;
    chk_zero("rst_in_slip_async");
    @(posedge iclk);
    #1;
    chk_zero("rst_in_slip_edge");
    RST = 1'b1;
    // counters cleared: first word reaches the FSM one edge later, slip on the 64th
    n = 0; got = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      step(D00, 1'b1);
      if (bitslip) begin n = i; got = 1'b1; break; end
    end
    chk("rst_slip_after", n, SEARCH_TIMEOUT + 1);

    // reset while in WAIT, then tokens must lock with no settle delay
    repeat (3) step(T00, 1'b1);
    chk("wait_no_slip", bitslip, 0);
    RST = 1'b0;
    #1;
    chk_zero("rst_in_wait_async");
    @(posedge iclk);
    #1;
    chk_zero("rst_in_wait_edge");
    RST = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step(T00, 1'b1);
      chk("rst_wait_slip", bitslip, 0);
      if (i == 8) chk("rst_wait_pre", aligned, 0);
      if (i == 9) chk("rst_wait_lock", aligned, 1);
    end

    // din_valid toggling during a token stream
    do_reset();
    vcnt = 0;
    for (int i = 1; i <= 24; i++) begin
      vh[i] = i[0];
      step(T00, vh[i]);
      chk("tog_vld", vld, (i >= 2) ? vh[i-1] : 1'b0);
      chk("tog_aligned", aligned, (vcnt >= TOKEN_CNT_MIN));
      if (vh[i]) vcnt++;
    end

    // randomized bursts of tokens and data against the reference model
    do_reset();
    for (int seg = 0; seg < 150; seg++) begin
      kind = $urandom_range(0, 2);
      r32 = $urandom;
      case (r32[1:0])
        2'd0: w = T00;
        2'd1: w = T01;
        2'd2: w = T10;
        default: w = T11;
      endcase
      len = (kind == 0) ? 10 : $urandom_range(1, 40);
      for (int k = 0; k < len; k++) begin
        if (kind != 0) begin
          r32 = $urandom;
          w = r32[9:0];
        end
        v = ($urandom_range(0, 7) != 0);
        step(w, v);
        model_edge(w, v);
        chk("rand_out", {bitslip, aligned, vld, de, c1, c0, dout},
            {o_slip, (m_mode == M_LOCKED), o_vld, o_de, o_c, o_dout});
`ifdef TMDS_LOST_CNT_EN
        chk("rand_lost", lost_cnt, m_lost);
`else
        chk("rand_lost", lost_cnt, 0);
`endif
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
